// File: rtl/multicycle_control_fsm.sv
// Control FSM for the multi-cycle RV32I core: sequences ALU, unified memory and
// register file through IF/ID/EX/MEM/WB, halts on a terminating ECALL, counts retires.
module multicycle_control_fsm #(
   parameter int unsigned CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [6:0]           opcode,
   input  logic                 mem_ready,
   input  logic                 bcond,
   input  logic                 halt_cond,
   output logic                 pc_write,
   output logic                 i_or_d,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 ir_write,
   output logic                 mem_to_reg,
   output logic                 reg_write,
   output logic                 pc_to_reg,
   output logic                 alu_src_a,
   output logic [1:0]           alu_src_b,
   output logic [1:0]           alu_op,
   output logic                 pc_source,
   output logic                 is_ecall,
   output logic                 is_halted,
   output logic [2:0]           state,
   output logic [CNT_WIDTH-1:0] retired_count
);

   localparam int unsigned OPC_W = 7;
   localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
   localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] OP_ECALL  = 7'b1110011;

   typedef enum logic [2:0] {
      S_IF   = 3'd0,
      S_ID   = 3'd1,
      S_EX   = 3'd2,
      S_MEM  = 3'd3,
      S_WB   = 3'd4,
      S_HALT = 3'd5
   } state_t;

   state_t               state_q, state_d, cur_st;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 retire_c;

   // While reset is asserted the outputs look like IF.
   assign cur_st        = reset_n ? state_q : S_IF;
   assign state         = cur_st;
   assign retired_count = cnt_q;

   always_comb begin
      pc_write   = 1'b0;
      i_or_d     = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      pc_to_reg  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_op     = 2'b00;
      pc_source  = 1'b0;
      is_ecall   = 1'b0;
      is_halted  = 1'b0;
      state_d    = cur_st;
      case (cur_st)
         S_IF: begin
            mem_read = 1'b1;
            ir_write = mem_ready;
            if (mem_ready) state_d = S_ID;
         end
         S_ID: begin
            alu_src_b = 2'b10;
            case (opcode)
               OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: state_d = S_EX;
               OP_ECALL: begin
                  is_ecall = 1'b1;
                  state_d  = halt_cond ? S_HALT : S_WB;
               end
               default: state_d = S_WB;
            endcase
         end
         S_EX: begin
            alu_src_a = 1'b1;
            state_d   = S_WB;
            case (opcode)
               OP_R: alu_op = 2'b10;
               OP_I: begin
                  alu_src_b = 2'b10;
                  alu_op    = 2'b11;
               end
               OP_LOAD, OP_STORE: begin
                  alu_src_b = 2'b10;
                  state_d   = S_MEM;
               end
               OP_JALR: alu_src_b = 2'b10;
               OP_BRANCH: begin
                  alu_op    = 2'b01;
                  pc_source = 1'b1;
                  pc_write  = bcond;
                  state_d   = bcond ? S_IF : S_WB;
               end
               default: alu_src_a = 1'b1;
            endcase
         end
         S_MEM: begin
            i_or_d = 1'b1;
            if (opcode == OP_STORE) begin
               mem_write = 1'b1;
               alu_src_b = 2'b01;
               pc_write  = mem_ready;
               if (mem_ready) state_d = S_IF;
            end else begin
               mem_read = 1'b1;
               if (mem_ready) state_d = S_WB;
            end
         end
         S_WB: begin
            alu_src_b = 2'b01;
            pc_write  = 1'b1;
            state_d   = S_IF;
            case (opcode)
               OP_R, OP_I: reg_write = 1'b1;
               OP_LOAD: begin
                  reg_write  = 1'b1;
                  mem_to_reg = 1'b1;
               end
               OP_JAL, OP_JALR: begin
                  reg_write = 1'b1;
                  pc_to_reg = 1'b1;
                  pc_source = 1'b1;
               end
               default: reg_write = 1'b0;
            endcase
         end
         S_HALT: is_halted = 1'b1;
         default: state_d = S_IF;
      endcase
   end

   // A halting ECALL retires on its way out of ID; the counter saturates.
   always_comb begin
      retire_c = pc_write | ((cur_st == S_ID) & (state_d == S_HALT));
      cnt_d    = cnt_q;
      if (retire_c && (cnt_q != {CNT_WIDTH{1'b1}})) cnt_d = cnt_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IF;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized instruction-level bench for multicycle_control_fsm: each instruction is
// expanded into its phase sequence from its class and memory wait counts, then checked per cycle.
module tb_multicycle_control_fsm;

   typedef enum int {C_R, C_I, C_LD, C_ST, C_BR, C_JAL, C_JALR, C_EC, C_NOP} cls_t;
   typedef enum int {P_IF = 0, P_ID = 1, P_EX = 2, P_MEM = 3, P_WB = 4, P_HALT = 5} phase_t;

   logic        clk = 1'b0;
   logic        reset_n, mem_ready, bcond, halt_cond;
   logic [6:0]  opcode;
   logic        pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_write;
   logic        pc_to_reg, alu_src_a, pc_source, is_ecall, is_halted;
   logic [1:0]  alu_src_b, alu_op;
   logic [2:0]  state;
   logic [31:0] retired_count;
   logic        s_pc_write, s_i_or_d, s_mem_read, s_mem_write, s_ir_write, s_mem_to_reg;
   logic        s_reg_write, s_pc_to_reg, s_alu_src_a, s_pc_source, s_is_ecall, s_is_halted;
   logic [1:0]  s_alu_src_b, s_alu_op;
   logic [2:0]  s_state;
   logic [3:0]  s_count;

   int n_checks = 0;
   int n_fail   = 0;
   int n_ret    = 0;
   int ir_pulses;
   logic [6:0] cur_op;

   always #5 clk = ~clk;

   multicycle_control_fsm #(.CNT_WIDTH(32)) dut (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready), .bcond(bcond),
      .halt_cond(halt_cond), .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read),
      .mem_write(mem_write), .ir_write(ir_write), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .pc_to_reg(pc_to_reg), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source), .is_ecall(is_ecall),
      .is_halted(is_halted), .state(state), .retired_count(retired_count)
   );

   multicycle_control_fsm #(.CNT_WIDTH(4)) dut_small (
      .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready), .bcond(bcond),
      .halt_cond(halt_cond), .pc_write(s_pc_write), .i_or_d(s_i_or_d),
      .mem_read(s_mem_read), .mem_write(s_mem_write), .ir_write(s_ir_write),
      .mem_to_reg(s_mem_to_reg), .reg_write(s_reg_write), .pc_to_reg(s_pc_to_reg),
      .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b), .alu_op(s_alu_op),
      .pc_source(s_pc_source), .is_ecall(s_is_ecall), .is_halted(s_is_halted),
      .state(s_state), .retired_count(s_count)
   );

   wire [15:0] vec   = {pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
                        reg_write, pc_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
                        is_ecall, is_halted};
   wire [15:0] s_vec = {s_pc_write, s_i_or_d, s_mem_read, s_mem_write, s_ir_write,
                        s_mem_to_reg, s_reg_write, s_pc_to_reg, s_alu_src_a, s_alu_src_b,
                        s_alu_op, s_pc_source, s_is_ecall, s_is_halted};

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [6:0] op_of(cls_t c);
      logic [6:0] nops [5] = '{7'b0110111, 7'b0010111, 7'b0001111, 7'b0000000, 7'b1111111};
      case (c)
         C_R:    return 7'b0110011;
         C_I:    return 7'b0010011;
         C_LD:   return 7'b0000011;
         C_ST:   return 7'b0100011;
         C_BR:   return 7'b1100011;
         C_JAL:  return 7'b1101111;
         C_JALR: return 7'b1100111;
         C_EC:   return 7'b1110011;
         default: return nops[$urandom_range(4, 0)];
      endcase
   endfunction

   // Control word each phase should present, straight from the per-state output table.
   function automatic logic [15:0] exp_vec(phase_t ph, cls_t c, logic rdy, logic bc);
      logic pcw = 0, iod = 0, mr = 0, mw = 0, irw = 0, m2r = 0, rw = 0, p2r = 0;
      logic asa = 0, psrc = 0, ec = 0, hl = 0;
      logic [1:0] asb = 0, aop = 0;
      case (ph)
         P_IF: begin mr = 1; irw = rdy; end
         P_ID: begin asb = 2; ec = (c == C_EC); end
         P_EX: begin
            asa = 1;
            if (c == C_R) aop = 2;
            else if (c == C_I) begin asb = 2; aop = 3; end
            else if (c == C_BR) begin aop = 1; psrc = 1; pcw = bc; end
            else asb = 2;
         end
         P_MEM: begin
            iod = 1;
            if (c == C_LD) mr = 1;
            else begin mw = 1; asb = 1; pcw = rdy; end
         end
         P_WB: begin
            asb = 1; pcw = 1;
            if (c == C_R || c == C_I) rw = 1;
            else if (c == C_LD) begin rw = 1; m2r = 1; end
            else if (c == C_JAL || c == C_JALR) begin rw = 1; p2r = 1; psrc = 1; end
         end
         default: hl = 1;
      endcase
      return {pcw, iod, mr, mw, irw, m2r, rw, p2r, asa, asb, aop, psrc, ec, hl};
   endfunction

   task automatic step(input phase_t ph, input cls_t c, input logic rdy, input logic bc,
                       input logic hc, input logic rst);
      logic   r, b;
      phase_t eph;
      @(negedge clk);
      r   = (ph == P_IF || ph == P_MEM || rst) ? rdy : 1'($urandom);
      b   = (ph == P_EX) ? bc : 1'($urandom);
      eph = rst ? P_IF : ph;
      reset_n   = !rst;
      opcode    = (ph == P_HALT) ? 7'($urandom) : cur_op;
      mem_ready = r;
      bcond     = b;
      halt_cond = (ph == P_ID) ? hc : 1'($urandom);
      #1;
      chk("state", state, 64'(eph));
      chk("outputs", vec, exp_vec(eph, c, r, b));
      chk("small_outputs", s_vec, exp_vec(eph, c, r, b));
      chk("small_state", s_state, 64'(eph));
      chk("count", retired_count, 64'(n_ret));
      chk("count_sat4", s_count, 64'((n_ret > 15) ? 15 : n_ret));
      chk("rd_and_wr", mem_read & mem_write, 0);
      chk("regw_and_memw", reg_write & mem_write, 0);
      ir_pulses += int'(ir_write);
      if (rst) n_ret = 0;
   endtask

   task automatic run_instr(input cls_t c, input int ifw, input int memw, input logic bc,
                            input logic hc);
      bit done = 0;
      cur_op    = op_of(c);
      ir_pulses = 0;
      repeat (ifw) step(P_IF, c, 0, bc, hc, 0);
      step(P_IF, c, 1, bc, hc, 0);
      step(P_ID, c, 0, bc, hc, 0);
      if (c == C_EC && hc) begin
         n_ret++;
         done = 1;
      end
      if (!done && c inside {C_R, C_I, C_LD, C_ST, C_BR, C_JALR}) begin
         step(P_EX, c, 0, bc, hc, 0);
         if (c == C_BR && bc) done = 1;
      end
      if (!done && (c == C_LD || c == C_ST)) begin
         repeat (memw) step(P_MEM, c, 0, bc, hc, 0);
         step(P_MEM, c, 1, bc, hc, 0);
         if (c == C_ST) done = 1;
      end
      if (!done) step(P_WB, c, 0, bc, hc, 0);
      if (!(c == C_EC && hc)) n_ret++;
      chk("ir_write_once", ir_pulses, 1);
   endtask

   initial begin
      reset_n = 0; mem_ready = 1; bcond = 0; halt_cond = 0; opcode = 0; cur_op = 0;
      step(P_IF, C_NOP, 1, 0, 0, 1);
      step(P_IF, C_NOP, 1, 0, 0, 1);

      run_instr(C_R,    0, 0, 0, 0);
      run_instr(C_LD,   2, 3, 0, 0);
      run_instr(C_BR,   0, 0, 1, 0);
      run_instr(C_BR,   0, 0, 0, 0);
      run_instr(C_EC,   0, 0, 0, 0);
      run_instr(C_JAL,  1, 0, 0, 0);
      run_instr(C_JALR, 0, 0, 0, 0);
      run_instr(C_ST,   1, 2, 0, 0);
      run_instr(C_I,    0, 0, 0, 0);
      run_instr(C_NOP,  0, 0, 0, 0);

      for (int i = 0; i < 60; i++)
         run_instr(cls_t'($urandom_range(8, 0)), int'($urandom_range(3, 0)),
                   int'($urandom_range(3, 0)), 1'($urandom), 1'b0);

      // Reset while a store is stalled in MEM.
      cur_op = op_of(C_ST);
      step(P_IF,  C_ST, 1, 0, 0, 0);
      step(P_ID,  C_ST, 0, 0, 0, 0);
      step(P_EX,  C_ST, 0, 0, 0, 0);
      step(P_MEM, C_ST, 0, 0, 0, 0);
      step(P_IF,  C_ST, 0, 0, 0, 1);

      for (int i = 0; i < 20; i++)
         run_instr(C_NOP, int'($urandom_range(2, 0)), 0, 1'b0, 1'b0);

      run_instr(C_EC, 1, 0, 0, 1);
      repeat (20) step(P_HALT, C_EC, 0, 0, 0, 0);

      step(P_IF, C_NOP, 0, 0, 0, 1);
      step(P_IF, C_NOP, 1, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
